// File: rtl/mesm6_ifetch.sv
// mesm6_ifetch: instruction prefetch FIFO issuing sequential word reads and
// presenting one half-word opcode per cycle to the microcode decoder.
module mesm6_ifetch #(
   parameter int ADDR_WIDTH = 15,
   parameter int WORD_WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect,
   input  logic [ADDR_WIDTH:0]           redirect_pc,
   output logic                          op_valid,
   input  logic                          op_ready,
   output logic [WORD_WIDTH/2-1:0]       op_word,
   output logic [ADDR_WIDTH:0]           op_pc,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          ibus_fetch,
   output logic [ADDR_WIDTH-1:0]         ibus_addr,
   input  logic [WORD_WIDTH-1:0]         ibus_input,
   input  logic                          ibus_done
);
   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int HW = WORD_WIDTH/2;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, ibus_addr_q, ibus_addr_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [LW-1:0] count_q, count_d;
   logic [WORD_WIDTH-1:0] mem_q [DEPTH];
   logic [WORD_WIDTH-1:0] mem_d [DEPTH];
   logic [WORD_WIDTH-1:0] head_word;
   logic push, pop, consume;

   assign op_valid = count_q != '0;
   assign head_word = mem_q[head_q];
   assign op_word = pc_q[0] ? head_word[HW-1:0] : head_word[WORD_WIDTH-1:HW];
   assign op_pc = pc_q;
   assign level = count_q;
   assign ibus_fetch = state_q != IDLE;
   assign ibus_addr = ibus_addr_q;

   always_comb begin
      consume = op_valid && op_ready;
      push = state_q == REQ && ibus_done && !redirect;
      pop = consume && pc_q[0] && !redirect;
      mem_d = mem_q;
      if (push) mem_d[tail_q] = ibus_input;
      pc_d = redirect ? redirect_pc : consume ? pc_q + (ADDR_WIDTH+1)'(1) : pc_q;
      fetch_addr_d = redirect ? redirect_pc[ADDR_WIDTH:1]
                   : push ? fetch_addr_q + ADDR_WIDTH'(1) : fetch_addr_q;
      head_d = redirect ? '0 : head_q + PW'(pop);
      tail_d = redirect ? '0 : tail_q + PW'(push);
      count_d = redirect ? '0 : count_q + LW'(push) - LW'(pop);
      // A request already on the bus cannot be withdrawn, so a redirect without done parks in DROP
      state_d = redirect ? ((state_q == IDLE || ibus_done) ? REQ : DROP)
              : state_q == IDLE ? (count_q < FULL ? REQ : IDLE)
              : !ibus_done ? state_q
              : state_q == REQ ? (count_d < FULL ? REQ : IDLE)
              : (count_q == FULL ? IDLE : REQ);
      ibus_addr_d = (state_q == IDLE || ibus_done) ? fetch_addr_d : ibus_addr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q <= '0;
         fetch_addr_q <= '0;
         ibus_addr_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         mem_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         ibus_addr_q <= ibus_addr_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         mem_q <= mem_d;
      end
   end
endmodule

// File: tb/tb_mesm6_ifetch.sv
// tb_mesm6_ifetch: directed checks of the prefetch unit against hand-computed
// opcode/address sequences; bus returns address-tagged words.
module tb_mesm6_ifetch;
   logic clk = 0, reset = 0, redirect = 0, op_ready = 0, done_en = 0;
   logic [15:0] redirect_pc = '0;
   logic op_valid, ibus_fetch, ibus_done;
   logic [23:0] op_word;
   logic [15:0] op_pc;
   logic [2:0] level;
   logic [14:0] ibus_addr;
   logic [47:0] ibus_input;
   int total = 0, bad = 0, nreq, exp_pc;

   function automatic logic [47:0] word(input logic [14:0] a);
      return {24'h100000 + 24'(a), 24'h200000 + 24'(a)};
   endfunction

   function automatic logic [23:0] op_of(input logic [15:0] p);
      return p[0] ? 24'h200000 + 24'(p[15:1]) : 24'h100000 + 24'(p[15:1]);
   endfunction

   always #5 clk = ~clk;
   assign ibus_done = done_en & ibus_fetch;
   assign ibus_input = word(ibus_addr);

   mesm6_ifetch dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .op_valid(op_valid), .op_ready(op_ready), .op_word(op_word), .op_pc(op_pc),
      .level(level), .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
      .ibus_input(ibus_input), .ibus_done(ibus_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      redirect = 0;
      op_ready = 0;
      done_en = 0;
      step();
      step();
      reset = 0;
   endtask

   initial begin
      #2;
      do_reset();
      chk("rst_valid", op_valid, 0);
      chk("rst_fetch", ibus_fetch, 0);
      chk("rst_addr", ibus_addr, 0);
      chk("rst_level", level, 0);
      chk("rst_pc", op_pc, 0);
      chk("rst_word", op_word, 0);
      done_en = 1;
      op_ready = 1;
      exp_pc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (op_valid) begin
            chk("seq_pc", op_pc, 64'(exp_pc));
            chk("seq_word", op_word, op_of(16'(exp_pc)));
            exp_pc++;
         end
      end
      chk("seq_count", 64'(exp_pc), 19);

      do_reset();
      done_en = 1;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ibus_fetch && ibus_done) begin
            chk("bp_addr", ibus_addr, 64'(nreq));
            nreq++;
         end
      end
      chk("bp_nreq", 64'(nreq), 4);
      chk("bp_idle", ibus_fetch, 0);
      chk("bp_full", level, 4);
      op_ready = 1;
      step();
      op_ready = 0;
      chk("bp_pulse1_level", level, 4);
      chk("bp_pulse1_pc", op_pc, 1);
      op_ready = 1;
      step();
      op_ready = 0;
      chk("bp_pulse2_level", level, 3);
      chk("bp_pulse2_word", op_word, 24'h100001);
      step();
      chk("bp_refetch", ibus_fetch, 1);
      chk("bp_refetch_addr", ibus_addr, 4);

      do_reset();
      done_en = 1;
      redirect = 1;
      redirect_pc = 16'h0007;
      step();
      redirect = 0;
      chk("odd_addr", ibus_addr, 3);
      chk("odd_fetch", ibus_fetch, 1);
      chk("odd_novalid", op_valid, 0);
      step();
      chk("odd_valid", op_valid, 1);
      chk("odd_pc", op_pc, 7);
      chk("odd_word", op_word, 24'h200003);
      op_ready = 1;
      step();
      op_ready = 0;
      chk("odd_next_pc", op_pc, 8);
      chk("odd_next_word", op_word, 24'h100004);

      do_reset();
      done_en = 1;
      step();
      step();
      step();
      chk("pend_addr", ibus_addr, 2);
      done_en = 0;
      redirect = 1;
      redirect_pc = 16'h0020;
      step();
      redirect = 0;
      chk("pend_hold1", ibus_addr, 2);
      chk("pend_flush", level, 0);
      step();
      chk("pend_hold2", ibus_addr, 2);
      step();
      chk("pend_hold3", ibus_addr, 2);
      chk("pend_fetch", ibus_fetch, 1);
      done_en = 1;
      step();
      chk("pend_newaddr", ibus_addr, 15'h10);
      chk("pend_dropped", op_valid, 0);
      step();
      chk("pend_valid", op_valid, 1);
      chk("pend_pc", op_pc, 16'h0020);
      chk("pend_word", op_word, 24'h100010);

      op_ready = 1;
      redirect = 1;
      redirect_pc = 16'h0100;
      step();
      redirect = 0;
      op_ready = 0;
      chk("rdc_level", level, 0);
      chk("rdc_valid", op_valid, 0);
      chk("rdc_pc", op_pc, 16'h0100);
      chk("rdc_addr", ibus_addr, 15'h80);
      step();
      chk("rdc_pc2", op_pc, 16'h0100);
      chk("rdc_word", op_word, 24'h100080);
      chk("rdc_level2", level, 1);

      redirect = 1;
      redirect_pc = 16'hFFFE;
      step();
      redirect = 0;
      op_ready = 1;
      chk("wrap_addr", ibus_addr, 15'h7FFF);
      step();
      chk("wrap_addr0", ibus_addr, 0);
      chk("wrap_pc0", op_pc, 16'hFFFE);
      chk("wrap_word0", op_word, 24'h107FFF);
      step();
      chk("wrap_pc1", op_pc, 16'hFFFF);
      chk("wrap_word1", op_word, 24'h207FFF);
      step();
      chk("wrap_pc2", op_pc, 16'h0000);
      chk("wrap_word2", op_word, 24'h100000);

      chk("areset_pre", ibus_fetch, 1);
      reset = 1;
      #1;
      chk("areset_fetch", ibus_fetch, 0);
      chk("areset_valid", op_valid, 0);
      chk("areset_level", level, 0);
      step();
      reset = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
